// File: rtl/multiplicador4x4_seq.sv
// Sequential 4x4 unsigned shift-add multiplier with a START/BUSY/DONE handshake.
// Optional macro MULT_ZERO_SKIP_EN: zero operands finish straight away, without CALC steps.
module multiplicador4x4_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P,
  output logic       Z,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;

  state_t     state;
  logic [3:0] ma, hi, lo;
  logic [1:0] cnt;
  logic [4:0] sum;
  logic [7:0] nxt;

  // One step: add MA when the multiplier LSB is set, then shift the 9-bit {carry, HI, LO} right.
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, ma} : 5'd0);
    nxt = {sum, lo[3:1]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ma    <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      P     <= '0;
      Z     <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
`ifdef MULT_ZERO_SKIP_EN
          if (START && (A == 4'd0 || B == 4'd0)) begin
            state <= FIM;
            P     <= '0;
            Z     <= 1'b1;
            DONE  <= 1'b1;
          end else
`endif
          if (START) begin
            ma    <= A;
            lo    <= B;
            hi    <= '0;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          hi  <= nxt[7:4];
          lo  <= nxt[3:0];
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            P     <= nxt;
            Z     <= (nxt == 8'h00);
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIM;
          end
        end
        FIM: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
